ps2_sam_keyboard: RTL and testbench
===================================

# ps2_sam_keyboard

PS/2 keyboard front end for the SAM Coupé core. It receives PS/2 set-2 scan codes and maintains a 9-row × 8-column SAM key matrix. It returns the active-low matrix columns for the row(s) the CPU currently addresses on A15..A8. It also exports PC function-key and modifier state, which the top level uses for NMI and reset hot-keys. It sits upstream of the ASIC port mux: `key_data[4:0]` feeds port 254 and `key_data[7:5]` feeds port 249.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical samples required before a PS/2 clk/data level change is accepted.
- `TIMEOUT_BITS`, 15: width of the in-frame watchdog; the frame aborts when the counter overflows (2^15 clk_sys cycles).
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ps2_kbd_clk` in 1: PS/2 clock, asynchronous.
- `ps2_kbd_data` in 1: PS/2 data, asynchronous.
- `addr` in 16: CPU address; A15..A8 select rows, active low.
- `key_data` out 8: active-low column data for the selected row(s); bits 4:0 are main keys, bits 7:5 are extra keys.
- `Fn` out 11 (`[11:1]`): PC F1..F11 held, active high.
- `mod` out 3: {alt, ctrl, shift} held, either side, active high.

## Operation
- **Input sync:** 2-FF synchroniser, then a FILTER_LEN glitch filter on both clk and data. A receive event is a filtered clk 1→0 transition.
- **Receiver FSM:**
  - IDLE: on event with data=0 go to DATA; data=1 is ignored.
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: if data=1 and the odd-parity check passes, pulse byte_valid for 1 cycle. Always return to IDLE.
  - Bad parity or stop=0 discards the byte with no state change.
- **Watchdog:** counts while not IDLE and clears on every event. On overflow, return to IDLE and discard the partial byte.
- **Decoder:**
  - 0xF0 sets the release flag.
  - 0xE0 sets the extended flag.
  - 0xE1 arms a skip counter that drops the next 7 bytes (Pause key).
  - Any other byte updates its matrix bit: press writes 0, release writes 1. Fn and mod are updated the same way (press writes 1). Both flags then clear.
  - Unmapped codes clear the flags only.
- **Matrix rows.** Bit order is b0..b4 | b5..b7. Row r is selected when A(8+r)=0:
  - A8: SHIFT Z X C V | F1 F2 F3
  - A9: A S D F G | F4 F5 F6
  - A10: Q W E R T | F7 F8 F9
  - A11: 1 2 3 4 5 | ESC TAB CAPS
  - A12: 0 9 8 7 6 | - + DEL
  - A13: P O I U Y | = " F0
  - A14: ENTER L K J H | ; : EDIT
  - A15: SPACE SYM M N B | , . INV
  - Row 8 (CTRL UP DOWN LEFT RIGHT in b0..b4, b7:5=1) is selected only when addr[15:8]=0xFF.
- **PC key mapping:**
  - Both shifts map to SHIFT.
  - Both ctrls map to SYM and also to row-8 CTRL.
  - Left alt maps to EDIT.
  - Backspace maps to DEL.
  - Keypad 0-9 map to F0-F9.
  - E0 arrows map to row 8.
  - Letters, digits and punctuation map to their positional equivalents.
- **key_data:** combinational bitwise AND of all selected rows. When no row is selected it is 0xFF.

## Timing
- **Reset values:** key_data=0xFF for every addr; all matrix bits=1; Fn=0; mod=0; FSM=IDLE; flags and skip counter cleared; filters set to 1.
- **Reset mid-frame:** abort immediately; no matrix change.
- **Addr to key_data:** 0 cycles (combinational).
- **Stop-bit event to byte_valid:** 1 cycle.
- **byte_valid to matrix, Fn and mod registers:** 1 cycle.
- **Line to key_data:** an input edge reaches key_data ≤ 2+FILTER_LEN+2 cycles after the pin changes.
- **Repeated prefixes:** a repeated 0xF0 or 0xE0 before a final code is idempotent.
- **Typematic repeat:** a repeated make code rewrites the same value.
- **byte_valid during skip:** the skip counter decrements and the byte is ignored.
- **Glitches:** a clk glitch shorter than FILTER_LEN cycles produces no event.

## Test plan
- Send make 0x1C (A), sample addr=0xFDFE (A9 low) → key_data=0xFE. Send F0 1C → 0xFF.
- Send 0x1A (Z) and 0x29 (SPACE) held, addr=0x7EFE (A8 and A15 low) → key_data=0xFC (Z b1, SPACE b0 ANDed). addr=0xFFFE → 0xFF.
- Send E0 75 (UP), addr=0xFFFE → key_data=0xFD. Send E0 F0 75 → 0xFF. Send plain 0x75 (KP8) → A10 row b6 low, key_data=0xBF at addr=0xFBFE.
- Send 0x14 then 0x78 → mod=3'b010, Fn[11]=1. Release both → mod=0, Fn=0.
- Send byte 0x1C with wrong parity → no matrix change. Start a frame, stop clocking for 2^15+1 cycles, then send valid 0x1C → A pressed (key_data=0xFE at 0xFDFE).
- Send E1 14 77 E1 F0 14 F0 77 (Pause), then 0x1C → only A pressed, mod=0. Assert reset → key_data=0xFF at all addresses, Fn=0, mod=0.

Source files
------------

// File: rtl/ps2_sam_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sam_keyboard
// Purpose  : PS/2 set-2 keyboard front end for the SAM Coupe core. Receives
//            scan codes, maintains the 9x8 SAM key matrix and returns the
//            active-low column data for the row(s) addressed on A15..A8.
//            Also exports PC F1..F11 and {alt, ctrl, shift} held state for
//            the NMI / reset hot-keys at the top level.
// Ports    : clk_sys       - system clock
//            reset         - synchronous, active-high reset
//            ps2_kbd_clk   - PS/2 clock line (asynchronous)
//            ps2_kbd_data  - PS/2 data line (asynchronous)
//            addr[15:0]    - CPU address, A15..A8 select rows (active low)
//            key_data[7:0] - active-low columns; [4:0] port 254, [7:5] port 249
//            Fn[11:1]      - PC F1..F11 held, active high
//            mod[2:0]      - {alt, ctrl, shift} held, active high
// Revision : 1.0 - initial release
// ============================================================================
module ps2_sam_keyboard #(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT_BITS = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [7:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);

  localparam int              FCW       = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILTER_LEN - 1);

  // --------------------------------------------------------------------------
  // Input synchronisers (reset to the idle-high line level)
  // --------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_kbd_clk};
      dat_sync <= {dat_sync[0], ps2_kbd_data};
    end
  end

  // --------------------------------------------------------------------------
  // Glitch filters: index 0 = clk, index 1 = data. The filtered level only
  // follows the synchronised level after FILTER_LEN consecutive samples that
  // differ from it; any agreeing sample restarts the count.
  // --------------------------------------------------------------------------
  logic [1:0] line_raw;
  logic [1:0] line_filt;

  assign line_raw = {dat_sync[1], clk_sync[1]};

  for (genvar i = 0; i < 2; i++) begin : g_filter
    logic [FCW-1:0] cnt;
    logic           filt;

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        cnt  <= '0;
        filt <= 1'b1;
      end else if (line_raw[i] == filt) begin
        cnt  <= '0;
      end else if (cnt == FILT_LAST) begin
        cnt  <= '0;
        filt <= line_raw[i];
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end

    assign line_filt[i] = filt;
  end

  // Receive event: filtered clk falling edge. Data is filtered with the same
  // delay, so the bit value is aligned with the event.
  logic clk_filt_q;
  logic ps2_event;
  logic ps2_bit;

  always_ff @(posedge clk_sys) begin
    if (reset) clk_filt_q <= 1'b1;
    else       clk_filt_q <= line_filt[0];
  end

  assign ps2_event = clk_filt_q & ~line_filt[0];
  assign ps2_bit   = line_filt[1];

  // --------------------------------------------------------------------------
  // Frame receiver with in-frame watchdog
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  rx_state_t               rx_state;
  logic [7:0]              rx_shift;
  logic [2:0]              rx_count;
  logic                    rx_parity;
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  logic                    byte_valid;
  logic [7:0]              rx_byte;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_shift   <= '0;
      rx_count   <= '0;
      rx_parity  <= 1'b0;
      wd_cnt     <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
    end else begin
      byte_valid <= 1'b0;

      if (rx_state == RX_IDLE || ps2_event) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + 1'b1;

      if (rx_state != RX_IDLE && !ps2_event && (&wd_cnt)) begin
        // Line went quiet mid-frame: drop the partial byte.
        rx_state <= RX_IDLE;
      end else if (ps2_event) begin
        case (rx_state)
          RX_IDLE: begin
            if (!ps2_bit) begin
              rx_state <= RX_DATA;
              rx_count <= '0;
            end
          end
          RX_DATA: begin
            rx_shift <= {ps2_bit, rx_shift[7:1]};
            rx_count <= rx_count + 1'b1;
            if (rx_count == 3'd7) rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            rx_parity <= ps2_bit;
            rx_state  <= RX_STOP;
          end
          RX_STOP: begin
            // Odd parity: data plus parity must hold an odd number of ones.
            if (ps2_bit && (^{rx_shift, rx_parity})) begin
              byte_valid <= 1'b1;
              rx_byte    <= rx_shift;
            end
            rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan-code lookup. loc = {hit, row[3:0], col[2:0]}.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] k(input int r, input int c);
    return {1'b1, 4'(r), 3'(c)};
  endfunction

  logic       rel_flag;
  logic       ext_flag;
  logic [7:0] loc;
  logic       ctrl_hit;   // either ctrl also drives row-8 CTRL
  logic       fn_hit;
  logic [3:0] fn_idx;
  logic       mod_hit;
  logic [1:0] mod_idx;

  always_comb begin
    loc      = '0;
    ctrl_hit = 1'b0;
    fn_hit   = 1'b0;
    fn_idx   = '0;
    mod_hit  = 1'b0;
    mod_idx  = '0;

    if (ext_flag) begin
      case (rx_byte)
        8'h14:   begin loc = k(7, 1); ctrl_hit = 1'b1; mod_hit = 1'b1; mod_idx = 2'd1; end
        8'h11:   begin mod_hit = 1'b1; mod_idx = 2'd2; end   // right alt: modifier only
        8'h5A:   loc = k(6, 0);                               // keypad enter
        8'h75:   loc = k(8, 1);
        8'h72:   loc = k(8, 2);
        8'h6B:   loc = k(8, 3);
        8'h74:   loc = k(8, 4);
        default: loc = '0;
      endcase
    end else begin
      case (rx_byte)
        8'h12, 8'h59: begin loc = k(0, 0); mod_hit = 1'b1; mod_idx = 2'd0; end
        8'h1A: loc = k(0, 1);  8'h22: loc = k(0, 2);  8'h21: loc = k(0, 3);
        8'h2A: loc = k(0, 4);  8'h69: loc = k(0, 5);  8'h72: loc = k(0, 6);
        8'h7A: loc = k(0, 7);
        8'h1C: loc = k(1, 0);  8'h1B: loc = k(1, 1);  8'h23: loc = k(1, 2);
        8'h2B: loc = k(1, 3);  8'h34: loc = k(1, 4);  8'h6B: loc = k(1, 5);
        8'h73: loc = k(1, 6);  8'h74: loc = k(1, 7);
        8'h15: loc = k(2, 0);  8'h1D: loc = k(2, 1);  8'h24: loc = k(2, 2);
        8'h2D: loc = k(2, 3);  8'h2C: loc = k(2, 4);  8'h6C: loc = k(2, 5);
        8'h75: loc = k(2, 6);  8'h7D: loc = k(2, 7);
        8'h16: loc = k(3, 0);  8'h1E: loc = k(3, 1);  8'h26: loc = k(3, 2);
        8'h25: loc = k(3, 3);  8'h2E: loc = k(3, 4);  8'h76: loc = k(3, 5);
        8'h0D: loc = k(3, 6);  8'h58: loc = k(3, 7);
        8'h45: loc = k(4, 0);  8'h46: loc = k(4, 1);  8'h3E: loc = k(4, 2);
        8'h3D: loc = k(4, 3);  8'h36: loc = k(4, 4);  8'h4E: loc = k(4, 5);
        8'h55: loc = k(4, 6);  8'h66: loc = k(4, 7);
        8'h4D: loc = k(5, 0);  8'h44: loc = k(5, 1);  8'h43: loc = k(5, 2);
        8'h3C: loc = k(5, 3);  8'h35: loc = k(5, 4);  8'h54: loc = k(5, 5);
        8'h5B: loc = k(5, 6);  8'h70: loc = k(5, 7);
        8'h5A: loc = k(6, 0);  8'h4B: loc = k(6, 1);  8'h42: loc = k(6, 2);
        8'h3B: loc = k(6, 3);  8'h33: loc = k(6, 4);  8'h4C: loc = k(6, 5);
        8'h52: loc = k(6, 6);
        8'h11: begin loc = k(6, 7); mod_hit = 1'b1; mod_idx = 2'd2; end
        8'h29: loc = k(7, 0);
        8'h14: begin loc = k(7, 1); ctrl_hit = 1'b1; mod_hit = 1'b1; mod_idx = 2'd1; end
        8'h3A: loc = k(7, 2);  8'h31: loc = k(7, 3);  8'h32: loc = k(7, 4);
        8'h41: loc = k(7, 5);  8'h49: loc = k(7, 6);  8'h4A: loc = k(7, 7);
        8'h05: begin fn_hit = 1'b1; fn_idx = 4'd1;  end
        8'h06: begin fn_hit = 1'b1; fn_idx = 4'd2;  end
        8'h04: begin fn_hit = 1'b1; fn_idx = 4'd3;  end
        8'h0C: begin fn_hit = 1'b1; fn_idx = 4'd4;  end
        8'h03: begin fn_hit = 1'b1; fn_idx = 4'd5;  end
        8'h0B: begin fn_hit = 1'b1; fn_idx = 4'd6;  end
        8'h83: begin fn_hit = 1'b1; fn_idx = 4'd7;  end
        8'h0A: begin fn_hit = 1'b1; fn_idx = 4'd8;  end
        8'h01: begin fn_hit = 1'b1; fn_idx = 4'd9;  end
        8'h09: begin fn_hit = 1'b1; fn_idx = 4'd10; end
        8'h78: begin fn_hit = 1'b1; fn_idx = 4'd11; end
        default: loc = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Decoder state and key matrix. Matrix bits are active low; row 8 bits 7:5
  // are never written and so always read as 1.
  // --------------------------------------------------------------------------
  logic [7:0] matrix [0:8];
  logic [2:0] skip_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int r = 0; r < 9; r++) matrix[r] <= 8'hFF;
      Fn       <= '0;
      mod      <= '0;
      rel_flag <= 1'b0;
      ext_flag <= 1'b0;
      skip_cnt <= '0;
    end else if (byte_valid) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 1'b1;
      end else if (rx_byte == 8'hF0) begin
        rel_flag <= 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hE1) begin
        // Pause sends E1 followed by seven bytes that carry no key.
        skip_cnt <= 3'd7;
      end else begin
        rel_flag <= 1'b0;
        ext_flag <= 1'b0;
        if (loc[7])   matrix[loc[6:3]][loc[2:0]] <= rel_flag;
        if (ctrl_hit) matrix[8][0]               <= rel_flag;
        if (fn_hit)   Fn[fn_idx]                 <= ~rel_flag;
        if (mod_hit)  mod[mod_idx]               <= ~rel_flag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Row readout: AND of every addressed row; row 8 only when A15..A8 all high.
  // --------------------------------------------------------------------------
  always_comb begin
    key_data = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (!addr[8+r]) key_data = key_data & matrix[r];
    end
    if (addr[15:8] == 8'hFF) key_data = key_data & matrix[8];
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_sam_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_sam_keyboard
// Purpose  : Self-checking bench for ps2_sam_keyboard. Table of scan-code
//            sequences with expected key_data / Fn / mod, followed by
//            hand-written sequences for latency, parity, watchdog, glitch,
//            Pause skipping and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_sam_keyboard;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] addr    = 16'hFFFE;
  logic [7:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;

  int checks = 0;
  int errors = 0;

  ps2_sam_keyboard #(
    .FILTER_LEN   (8),
    .TIMEOUT_BITS (15)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_clk),
    .ps2_kbd_data (ps2_dat),
    .addr         (addr),
    .key_data     (key_data),
    .Fn           (Fn),
    .mod          (mod)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [15:0] a;
    logic [7:0]  kd;
    logic [11:1] fn;
    logic [2:0]  md;
  } vec_t;

  vec_t vecs [0:39];
  int   nv = 0;

  task automatic add(input int n, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input logic [15:0] a, input logic [7:0] kd,
                     input logic [11:1] fn, input logic [2:0] md);
    vecs[nv] = '{n, b0, b1, b2, a, kd, fn, md};
    nv++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    ps2_dat = b;
    cyc(12);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(12);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(p);
    bit_out(1'b1);
  endtask

  task automatic probe(input string name, input logic [15:0] a, input logic [7:0] kd,
                       input logic [11:1] fn, input logic [2:0] md);
    addr = a;
    #1;
    check({name, "_kd"},  {8'h00, key_data}, {8'h00, kd});
    check({name, "_fn"},  {5'h00, Fn},       {5'h00, fn});
    check({name, "_mod"}, {13'h0, mod},      {13'h0, md});
  endtask

  initial begin
    int            lat;
    logic [7:0]    pause_seq [0:7];
    logic [15:0]   rst_addrs [0:9];

    //        n  b0     b1     b2     addr      kd     Fn       mod
    add(0, 8'h00, 8'h00, 8'h00, 16'hFDFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h1C, 8'h00, 8'h00, 16'hFDFE, 8'hFE, 11'h000, 3'd0);  // A
    add(1, 8'h1C, 8'h00, 8'h00, 16'hFDFE, 8'hFE, 11'h000, 3'd0);  // typematic
    add(3, 8'hF0, 8'hF0, 8'h1C, 16'hFDFE, 8'hFF, 11'h000, 3'd0);  // repeated F0
    add(1, 8'h1A, 8'h00, 8'h00, 16'h7EFE, 8'hFD, 11'h000, 3'd0);  // Z
    add(1, 8'h29, 8'h00, 8'h00, 16'h7EFE, 8'hFC, 11'h000, 3'd0);  // + SPACE
    add(0, 8'h00, 8'h00, 8'h00, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h1A, 8'h00, 16'h7EFE, 8'hFE, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h29, 8'h00, 16'h7EFE, 8'hFF, 11'h000, 3'd0);
    add(2, 8'hE0, 8'h75, 8'h00, 16'hFFFE, 8'hFD, 11'h000, 3'd0);  // UP
    add(3, 8'hE0, 8'hE0, 8'h75, 16'hFFFE, 8'hFD, 11'h000, 3'd0);  // repeated E0
    add(3, 8'hE0, 8'hF0, 8'h75, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h75, 8'h00, 8'h00, 16'hFBFE, 8'hBF, 11'h000, 3'd0);  // KP8 -> F8
    add(2, 8'hF0, 8'h75, 8'h00, 16'hFBFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h14, 8'h00, 8'h00, 16'h7FFE, 8'hFD, 11'h000, 3'd2);  // ctrl -> SYM
    add(1, 8'h78, 8'h00, 8'h00, 16'hFFFE, 8'hFE, 11'h400, 3'd2);  // F11, row-8 CTRL
    add(2, 8'hF0, 8'h14, 8'h00, 16'hFFFE, 8'hFF, 11'h400, 3'd0);
    add(2, 8'hF0, 8'h78, 8'h00, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h12, 8'h00, 8'h00, 16'hFEFE, 8'hFE, 11'h000, 3'd1);  // left shift
    add(1, 8'h59, 8'h00, 8'h00, 16'hFEFE, 8'hFE, 11'h000, 3'd1);  // right shift
    add(2, 8'hF0, 8'h12, 8'h00, 16'hFEFE, 8'hFF, 11'h000, 3'd0);
    add(2, 8'hF0, 8'h59, 8'h00, 16'hFEFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h11, 8'h00, 8'h00, 16'hBFFE, 8'h7F, 11'h000, 3'd4);  // left alt -> EDIT
    add(2, 8'hF0, 8'h11, 8'h00, 16'hBFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h66, 8'h00, 8'h00, 16'hEFFE, 8'h7F, 11'h000, 3'd0);  // backspace -> DEL
    add(2, 8'hF0, 8'h66, 8'h00, 16'hEFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h05, 8'h00, 8'h00, 16'hFFFE, 8'hFF, 11'h001, 3'd0);  // F1
    add(2, 8'hF0, 8'h05, 8'h00, 16'hFFFE, 8'hFF, 11'h000, 3'd0);
    add(1, 8'h1B, 8'h00, 8'h00, 16'h0000, 8'hFD, 11'h000, 3'd0);  // S, all rows
    add(2, 8'hF0, 8'h1B, 8'h00, 16'h0000, 8'hFF, 11'h000, 3'd0);

    // Reset state
    cyc(5);
    reset = 1'b0;
    cyc(2);
    probe("reset0", 16'h0000, 8'hFF, 11'h000, 3'd0);
    probe("reset1", 16'hFFFE, 8'hFF, 11'h000, 3'd0);

    // Table
    for (int i = 0; i < nv; i++) begin
      if (vecs[i].n >= 1) send_byte(vecs[i].b0, 1'b0);
      if (vecs[i].n >= 2) send_byte(vecs[i].b1, 1'b0);
      if (vecs[i].n >= 3) send_byte(vecs[i].b2, 1'b0);
      probe($sformatf("v%0d", i), vecs[i].a, vecs[i].kd, vecs[i].fn, vecs[i].md);
    end

    // Latency from the stop-bit clock fall to key_data
    addr = 16'hFDFE;
    begin
      logic [7:0] b;
      b = 8'h1C;
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(~^b);
      ps2_dat = 1'b1;
      cyc(12);
      ps2_clk = 1'b0;
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
        @(posedge clk_sys);
        #1;
        if (key_data == 8'hFE) begin
          lat = i;
          break;
        end
      end
      checks++;
      if (lat < 1 || lat > 12) begin
        errors++;
        $display("FAIL latency: got %0d cycles (0 = never), required 1..12", lat);
      end
      cyc(20);
      ps2_clk = 1'b1;
      cyc(12);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    probe("lat_rel", 16'hFDFE, 8'hFF, 11'h000, 3'd0);

    // Bad parity: byte discarded
    send_byte(8'h1C, 1'b1);
    probe("badpar", 16'hFDFE, 8'hFF, 11'h000, 3'd0);

    // Watchdog: abandoned partial frame, then a clean frame
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    ps2_dat = 1'b1;
    cyc(32768 + 200);
    send_byte(8'h1C, 1'b0);
    probe("wdog", 16'hFDFE, 8'hFE, 11'h000, 3'd0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    probe("wdog_rel", 16'hFDFE, 8'hFF, 11'h000, 3'd0);

    // Short clk glitch with data low must not start a frame
    ps2_dat = 1'b0;
    cyc(20);
    ps2_clk = 1'b0;
    cyc(6);
    ps2_clk = 1'b1;
    cyc(20);
    ps2_dat = 1'b1;
    cyc(20);
    send_byte(8'h1C, 1'b0);
    probe("glitch", 16'hFDFE, 8'hFE, 11'h000, 3'd0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    probe("glitch_rel", 16'hFDFE, 8'hFF, 11'h000, 3'd0);

    // Pause sequence is skipped, following key still decodes
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 1'b0);
    send_byte(8'h1C, 1'b0);
    probe("pause_a", 16'hFDFE, 8'hFE, 11'h000, 3'd0);
    probe("pause_sym", 16'h7FFE, 8'hFF, 11'h000, 3'd0);
    probe("pause_r8", 16'hFFFE, 8'hFF, 11'h000, 3'd0);

    // Reset mid-frame with A held and Fn/mod set
    send_byte(8'h14, 1'b0);
    send_byte(8'h09, 1'b0);
    probe("pre_rst", 16'hFDFE, 8'hFE, 11'h200, 3'd2);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    ps2_dat = 1'b1;
    reset   = 1'b1;
    cyc(3);
    reset   = 1'b0;
    cyc(2);
    rst_addrs = '{16'hFEFE, 16'hFDFE, 16'hFBFE, 16'hF7FE, 16'hEFFE,
                  16'hDFFE, 16'hBFFE, 16'h7FFE, 16'hFFFE, 16'h0000};
    for (int i = 0; i < 10; i++)
      probe($sformatf("rst%0d", i), rst_addrs[i], 8'hFF, 11'h000, 3'd0);
    send_byte(8'h1C, 1'b0);
    probe("post_rst", 16'hFDFE, 8'hFE, 11'h000, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
